// File: rtl/apb_regfile.sv
// APB4 slave register file: REGWN byte-strobed RW control registers, REGRN RO status
// registers, programmable wait states and PSLVERR on RO writes and unmapped accesses.
module apb_regfile #(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 32,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 8,
  parameter int WAIT_STATES      = 0,
  parameter logic [DWIDTH-1:0] RESET_VAL = {DWIDTH{1'b0}}
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  input  logic [DWIDTH/8-1:0]     PSTRB,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [REGWN*DWIDTH-1:0] regw_q,
  input  logic [REGRN*DWIDTH-1:0] regr_d,
  output logic [REGWN-1:0]        wr_pulse
);

  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_s;
  logic [DWIDTH-1:0]     regw_r [REGWN];
  logic [DWIDTH-1:0]     prdata_r;
  logic [DWIDTH-1:0]     prdata_s;
  logic                  pready_r;
  logic                  pready_s;
  logic                  pslverr_r;
  logic                  pslverr_s;
  logic [REGWN-1:0]      wr_pulse_r;
  logic [REGWN-1:0]      wr_pulse_s;
  logic [31:0]           addr_ext_s;
  logic                  rw_hit_s;
  logic                  ro_hit_s;
  logic                  we_s;
  logic [DWIDTH-1:0]     rd_data_s;

  // Address decode; the gap between the RW and RO windows decodes as unmapped.
  always_comb begin
    addr_ext_s = 32'(PADDR);
    rw_hit_s   = (addr_ext_s < 32'(REGWN));
    ro_hit_s   = (addr_ext_s >= 32'(REGR_ADDR_OFFSET)) &&
                 (addr_ext_s < 32'(REGR_ADDR_OFFSET + REGRN));
  end

  // Transfer FSM next-state and wait counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          cnt_s   = 4'(WAIT_STATES);
          state_s = (WAIT_STATES == 0) ? DONE : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_s = IDLE;
        end else if (PENABLE) begin
          cnt_s = cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Read mux as an AND-OR tree over both register windows.
  always_comb begin
    rd_data_s = {DWIDTH{1'b0}};
    for (int i = 0; i < REGWN; i++) begin
      rd_data_s = rd_data_s | ({DWIDTH{addr_ext_s == 32'(i)}} & regw_r[i]);
    end
    for (int j = 0; j < REGRN; j++) begin
      rd_data_s = rd_data_s |
                  ({DWIDTH{addr_ext_s == 32'(REGR_ADDR_OFFSET + j)}} & regr_d[j*DWIDTH +: DWIDTH]);
    end
  end

  // Response values captured on the edge entering DONE; write commit on the edge leaving it.
  always_comb begin
    pready_s   = (state_s == DONE);
    prdata_s   = (pready_s && !PWRITE) ? rd_data_s : {DWIDTH{1'b0}};
    pslverr_s  = pready_s && (PWRITE ? !rw_hit_s : !(rw_hit_s || ro_hit_s));
    we_s       = (state_r == DONE) && PSEL && PENABLE && PWRITE && rw_hit_s;
    wr_pulse_s = {REGWN{1'b0}};
    for (int i = 0; i < REGWN; i++) begin
      wr_pulse_s[i] = we_s && (addr_ext_s == 32'(i)) && (|PSTRB);
    end
  end

  // FSM state, counter and registered APB response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      prdata_r   <= {DWIDTH{1'b0}};
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      wr_pulse_r <= {REGWN{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      prdata_r   <= prdata_s;
      pready_r   <= pready_s;
      pslverr_r  <= pslverr_s;
      wr_pulse_r <= wr_pulse_s;
    end
  end

  // RW register array with per-byte write enables; reset drops a coincident write.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < REGWN; i++) begin
        regw_r[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < REGWN; i++) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (we_s && (addr_ext_s == 32'(i)) && PSTRB[k]) begin
            regw_r[i][8*k +: 8] <= PWDATA[8*k +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REGWN; g++) begin : g_regw_q
    assign regw_q[g*DWIDTH +: DWIDTH] = regw_r[g];
  end

  assign PRDATA   = prdata_r;
  assign PREADY   = pready_r;
  assign PSLVERR  = pslverr_r;
  assign wr_pulse = wr_pulse_r;

endmodule
